// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to let divide-by-zero and signed overflow skip the CALC phase.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [4:0]  reg_waddr_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic [4:0]  reg_waddr_o
);

  typedef enum logic [1:0] {StIdle, StStart, StCalc, StEnd} state_e;

  state_e      r_state;
  logic [2:0]  r_op;
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_result;
  logic [4:0]  r_waddr;
  logic [4:0]  r_cnt;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_div0;
  logic        r_ovf;
  logic        r_ready;

  logic        w_signed;
  logic        w_is_rem;
  logic        w_dvd_neg;
  logic        w_dvs_neg;
  logic [31:0] w_dvd_abs;
  logic [31:0] w_dvs_abs;
  logic        w_div0_now;
  logic        w_ovf_now;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_bit;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_quo_fin;
  logic [31:0] w_rem_fin;
  logic [31:0] w_calc_res;

  function automatic logic [31:0] special_res(input logic div0, input logic is_rem,
                                              input logic [31:0] dvd);
    if (div0) return is_rem ? dvd : 32'hFFFF_FFFF;
    return is_rem ? 32'h0 : 32'h8000_0000;
  endfunction

  // op[0]=0 selects signed, op[1]=1 selects remainder; non-M codes fall back to quotient
  assign w_signed   = ~r_op[0];
  assign w_is_rem   = r_op[2] & r_op[1];
  assign w_dvd_neg  = w_signed & r_dvd[31];
  assign w_dvs_neg  = w_signed & r_dvs[31];
  assign w_dvd_abs  = w_dvd_neg ? (~r_dvd + 32'd1) : r_dvd;
  assign w_dvs_abs  = w_dvs_neg ? (~r_dvs + 32'd1) : r_dvs;
  assign w_div0_now = (r_dvs == 32'h0);
  assign w_ovf_now  = w_signed & (r_dvd == 32'h8000_0000) & (r_dvs == 32'hFFFF_FFFF);

  // Dividend shifts out of r_quo MSB-first while quotient bits shift in at the bottom
  assign w_rem_sh   = {r_rem, r_quo[31]};
  assign w_diff     = w_rem_sh - {1'b0, r_dvs};
  assign w_bit      = ~w_diff[32];
  assign w_rem_nx   = w_bit ? w_diff[31:0] : w_rem_sh[31:0];
  assign w_quo_nx   = {r_quo[30:0], w_bit};
  assign w_quo_fin  = r_q_neg ? (~w_quo_nx + 32'd1) : w_quo_nx;
  assign w_rem_fin  = r_r_neg ? (~w_rem_nx + 32'd1) : w_rem_nx;
  assign w_calc_res = (r_div0 | r_ovf) ? special_res(r_div0, w_is_rem, r_dvd)
                                       : (w_is_rem ? w_rem_fin : w_quo_fin);

  assign busy_o      = (r_state == StStart) || (r_state == StCalc) ||
                       ((r_state == StIdle) && start_i && !abort_i);
  assign ready_o     = r_ready;
  assign result_o    = r_ready ? r_result : 32'h0;
  assign reg_waddr_o = r_ready ? r_waddr : 5'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_op     <= 3'h0;
      r_dvd    <= 32'h0;
      r_dvs    <= 32'h0;
      r_quo    <= 32'h0;
      r_rem    <= 32'h0;
      r_result <= 32'h0;
      r_waddr  <= 5'h0;
      r_cnt    <= 5'h0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_ready  <= 1'b0;
    end else if (abort_i) begin
      r_state <= StIdle;
      r_ready <= 1'b0;
      r_cnt   <= 5'h0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_ready <= 1'b0;
          if (start_i) begin
            r_op    <= op_i;
            r_dvd   <= dividend_i;
            r_dvs   <= divisor_i;
            r_waddr <= reg_waddr_i;
            r_state <= StStart;
          end
        end
        StStart: begin
          r_quo   <= w_dvd_abs;
          r_rem   <= 32'h0;
          r_dvs   <= w_dvs_abs;
          r_q_neg <= w_dvd_neg ^ w_dvs_neg;
          r_r_neg <= w_dvd_neg;
          r_div0  <= w_div0_now;
          r_ovf   <= w_ovf_now;
          r_cnt   <= 5'h0;
`ifdef DIV_EARLY_OUT_EN
          if (w_div0_now || w_ovf_now) begin
            r_result <= special_res(w_div0_now, w_is_rem, r_dvd);
            r_ready  <= 1'b1;
            r_state  <= StEnd;
          end else begin
            r_state <= StCalc;
          end
`else
          r_state <= StCalc;
`endif
        end
        StCalc: begin
          r_quo <= w_quo_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_result <= w_calc_res;
            r_ready  <= 1'b1;
            r_state  <= StEnd;
          end
        end
        StEnd: begin
          r_ready <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
